// File: rtl/pkt_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants lock for a whole packet; a beat-count watchdog truncates runaway packets.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters starting after last_r
// BUSY  | grant held by grant_id; beats of that packet flow to the FIFO
module pkt_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 64,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [DATA_WIDTH+ID_W:0]       fifo_wr_data,
    output logic                           grant_valid,
    output logic [ID_W-1:0]                grant_id,
    output logic                           pkt_err,
    input  logic                           err_clr
);

    localparam int BW = $clog2(MAX_BEATS);
    localparam logic [BW-1:0] BEAT_LIMIT = BW'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_r, state_nxt;
    logic [ID_W-1:0]      grant_id_r, grant_nxt;
    logic [ID_W-1:0]      last_r, last_nxt;
    logic [BW-1:0]        beats_r, beats_nxt;
    logic                 pkt_err_r;
    logic                 last_out;
    logic                 beat_acc;
    logic                 trunc;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ID_W:0]        pick_idle;
    logic [ID_W:0]        pick_eop;

    // Returns {found, index}: first valid requester searching from ptr+1, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] win;
        int              idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && vld[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        return {found, win};
    endfunction

    // At end of packet the current grantee is excluded so others get a turn.
    assign pick_idle = rr_pick(req_valid, last_r);
    assign pick_eop  = rr_pick(req_valid & ~(NUM_REQ'(1) << grant_id_r), grant_id_r);

    assign sel_data = req_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
    assign last_out = req_last[grant_id_r] || (beats_r == BEAT_LIMIT);

    always_comb begin
        state_nxt  = state_r;
        grant_nxt  = grant_id_r;
        last_nxt   = last_r;
        beats_nxt  = beats_r;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        beat_acc   = 1'b0;
        trunc      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_idle[ID_W]) begin
                    grant_nxt = pick_idle[ID_W-1:0];
                    last_nxt  = pick_idle[ID_W-1:0];
                    beats_nxt = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                req_ready[grant_id_r] = !fifo_full;
                beat_acc              = req_valid[grant_id_r] && !fifo_full;
                fifo_wr_en            = beat_acc;
                if (beat_acc) begin
                    trunc = !req_last[grant_id_r] && (beats_r == BEAT_LIMIT);
                    if (last_out) begin
                        beats_nxt = '0;
                        if (pick_eop[ID_W]) begin
                            grant_nxt = pick_eop[ID_W-1:0];
                            last_nxt  = pick_eop[ID_W-1:0];
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        beats_nxt = beats_r + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            last_r     <= ID_W'(NUM_REQ - 1);
            beats_r    <= '0;
            pkt_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            grant_id_r <= grant_nxt;
            last_r     <= last_nxt;
            beats_r    <= beats_nxt;
            // A truncation in the same cycle as a clear must not be lost.
            if (trunc) begin
                pkt_err_r <= 1'b1;
            end else if (err_clr) begin
                pkt_err_r <= 1'b0;
            end
        end
    end

    assign fifo_wr_data = {grant_id_r, last_out, sel_data};
    assign grant_valid  = (state_r == BUSY);
    assign grant_id     = grant_id_r;
    assign pkt_err      = pkt_err_r;

endmodule

// File: tb/tb_pkt_wr_arbiter.sv
// Scoreboard bench for pkt_wr_arbiter: stimulus queues expected FIFO words,
// an independent monitor pops and compares every presented write.
module tb_pkt_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int IW = 2;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ready;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [DW+IW:0]     fifo_wr_data;
    logic               grant_valid;
    logic [IW-1:0]      grant_id;
    logic               pkt_err;
    logic               err_clr;

    pkt_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .pkt_err      (pkt_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW:0]    src_q [NR][$];
    logic [DW+IW:0] exp_q [$];
    logic [NR-1:0]  acc;
    logic           full_next;
    logic           clr_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic src_pkt(input int r, input int n, input logic [DW-1:0] base, input bit term);
        for (int k = 0; k < n; k++)
            src_q[r].push_back({1'(term && (k == n - 1)), base + DW'(k)});
    endtask

    task automatic exp_word(input int id, input bit last, input logic [DW-1:0] data);
        exp_q.push_back({IW'(id), last, data});
    endtask

    task automatic exp_pkt(input int id, input int n, input logic [DW-1:0] base, input bit term);
        for (int k = 0; k < n; k++)
            exp_word(id, term && (k == n - 1), base + DW'(k));
    endtask

    // One cycle: retire beats accepted on the last edge, drive new inputs, sample acceptance.
    task automatic step();
        logic [DW:0] b;
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        fifo_full = full_next;
        err_clr   = clr_next;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                req_valid[i]           = 1'b1;
                req_last[i]            = b[DW];
                req_data[i*DW +: DW]   = b[DW-1:0];
            end else begin
                req_valid[i]           = 1'b0;
                req_last[i]            = 1'b0;
                req_data[i*DW +: DW]   = '0;
            end
        end
        #1;
        acc = req_valid & req_ready;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        err_clr   = 1'b0;
        full_next = 1'b0;
        clr_next  = 1'b0;
        acc       = '0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every word the DUT presents for writing.
    always begin
        logic [DW+IW:0] e;
        @(negedge clk);
        #2;
        if (rst_n && fifo_full) chk("wr_en_while_full", 32'(fifo_wr_en), 0);
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_word", 32'(fifo_wr_data), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int gid_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_id",    32'(grant_id),    0);
        chk("rst_req_ready",   32'(req_ready),   0);
        chk("rst_wr_en",       32'(fifo_wr_en),  0);
        chk("rst_pkt_err",     32'(pkt_err),     0);

        // Single 3-beat packet from requester 0.
        do_reset();
        src_pkt(0, 3, 16'h1100, 1);
        exp_pkt(0, 3, 16'h1100, 1);
        step();
        chk("t1_c0_grant_valid", 32'(grant_valid), 0);
        chk("t1_c0_wr_en",       32'(fifo_wr_en),  0);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t1_grant_valid", 32'(grant_valid), 1);
            chk("t1_grant_id",    32'(grant_id),    0);
            chk("t1_wr_en",       32'(fifo_wr_en),  1);
        end
        step();
        chk("t1_c4_idle", 32'(grant_valid), 0);

        // All four requesters, 2-beat packets; requester 0 has a second packet.
        do_reset();
        src_pkt(0, 2, 16'h2000, 1);
        src_pkt(0, 2, 16'h2010, 1);
        src_pkt(1, 2, 16'h2100, 1);
        src_pkt(2, 2, 16'h2200, 1);
        src_pkt(3, 2, 16'h2300, 1);
        exp_pkt(0, 2, 16'h2000, 1);
        exp_pkt(1, 2, 16'h2100, 1);
        exp_pkt(2, 2, 16'h2200, 1);
        exp_pkt(3, 2, 16'h2300, 1);
        exp_pkt(0, 2, 16'h2010, 1);
        step();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t2_wr_en",    32'(fifo_wr_en), 1);
            chk("t2_grant_id", 32'(grant_id),   32'(gid_exp[c]));
        end
        step();
        chk("t2_end_idle", 32'(grant_valid), 0);

        // FIFO full for 5 cycles in the middle of requester 2's packet.
        do_reset();
        src_pkt(2, 3, 16'h3200, 1);
        exp_pkt(2, 3, 16'h3200, 1);
        step();
        step();
        chk("t3_first_beat", 32'(fifo_wr_en), 1);
        full_next = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_ready2_full", 32'(req_ready[2]), 0);
            chk("t3_wr_en_full",  32'(fifo_wr_en),   0);
            chk("t3_grant_id",    32'(grant_id),     2);
        end
        full_next = 1'b0;
        step();
        chk("t3_resume_wr", 32'(fifo_wr_en),   1);
        chk("t3_ready2",    32'(req_ready[2]), 1);
        step();
        step();
        chk("t3_end_idle", 32'(grant_valid), 0);

        // Watchdog: requester 1 sends 6 beats with no last, MAX_BEATS=4.
        do_reset();
        src_pkt(1, 6, 16'h4100, 0);
        exp_pkt(1, 3, 16'h4100, 0);
        exp_word(1, 1, 16'h4103);
        exp_pkt(1, 2, 16'h4104, 0);
        step();
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("t4_grant_id", 32'(grant_id), 1);
            chk("t4_pkt_err_before", 32'(pkt_err), 0);
        end
        step();
        chk("t4_pkt_err_set",  32'(pkt_err),     1);
        chk("t4_regrant_idle", 32'(grant_valid), 0);
        step();
        step();
        chk("t4_new_grant", 32'(grant_valid), 1);
        step();
        chk("t4_held_no_wr", 32'(fifo_wr_en),  0);
        chk("t4_held_grant", 32'(grant_valid), 1);
        clr_next = 1'b1;
        step();
        chk("t4_err_before_clr", 32'(pkt_err), 1);
        clr_next = 1'b0;
        step();
        chk("t4_err_cleared", 32'(pkt_err), 0);

        // Requester 3 streams packets; requester 0 joins during the first one.
        do_reset();
        src_pkt(3, 3, 16'h5300, 1);
        src_pkt(3, 3, 16'h5310, 1);
        exp_pkt(3, 3, 16'h5300, 1);
        exp_pkt(0, 2, 16'h5000, 1);
        exp_pkt(3, 3, 16'h5310, 1);
        step();
        step();
        chk("t5_first_grant", 32'(grant_id), 3);
        src_pkt(0, 2, 16'h5000, 1);
        step();
        step();
        step();
        chk("t5_grant_to_0", 32'(grant_id), 0);
        step();
        step();
        chk("t5_back_to_3", 32'(grant_id), 3);
        step();
        step();
        step();
        chk("t5_end_idle", 32'(grant_valid), 0);

        // Asynchronous reset in the middle of requester 2's packet.
        do_reset();
        src_pkt(2, 3, 16'h6200, 1);
        exp_pkt(2, 2, 16'h6200, 0);
        step();
        step();
        step();
        chk("t6_busy_before", 32'(grant_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_grant_valid", 32'(grant_valid), 0);
        chk("t6_async_wr_en",       32'(fifo_wr_en),  0);
        chk("t6_async_req_ready",   32'(req_ready),   0);
        do_reset();
        src_pkt(3, 1, 16'h6300, 1);
        src_pkt(0, 1, 16'h6000, 1);
        exp_pkt(0, 1, 16'h6000, 1);
        exp_pkt(3, 1, 16'h6300, 1);
        step();
        step();
        chk("t6_prio0_after_rst", 32'(grant_id), 0);
        step();
        chk("t6_then_3", 32'(grant_id), 3);
        step();
        step();
        chk("leftover_expected", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
